// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared character codes and sequencer state encoding
package msg_pkg;

    localparam int              CODE_W   = 4;
    localparam logic [CODE_W-1:0] CODE_DP  = 4'd10;
    localparam logic [CODE_W-1:0] CODE_MAX = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/msg_buffer.sv
// rtl/msg_buffer.sv - DEPTH x CODE_W message store, one write port, async read
module msg_buffer
    import msg_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [CODE_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [CODE_W-1:0]        rdata
);

    logic [CODE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/msg_sequencer.sv
// rtl/msg_sequencer.sv - plays a stored character message to a display; MSG_SEQUENCER_LOOP_EN enables looping
module msg_sequencer
    import msg_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int GAP_TICKS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick,
    input  logic                   wr_en,
    input  logic [3:0]             wr_data,
    input  logic                   clear,
    input  logic                   play,
    input  logic                   stop,
    input  logic                   loop,
    input  logic [7:0]             dwell,
    output logic [3:0]             code,
    output logic                   blank,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] len,
    output logic                   err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [7:0]        timer;
    logic [7:0]        dwell_eff;
    logic [AW-1:0]     nxt_idx;
    logic [AW-1:0]     rd_addr;
    logic [CODE_W-1:0] rd_code;
    logic [CODE_W-1:0] rd_safe;
    logic              full;
    logic              wr_ok;
    logic              last;
    logic              step_now;
    logic              loop_active;

`ifdef MSG_SEQUENCER_LOOP_EN
    assign loop_active = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign loop_active = 1'b0;
`endif

    assign dwell_eff = (dwell == 8'd0) ? 8'd1 : dwell;
    assign full      = (len == LW'(DEPTH));
    assign wr_ok     = wr_en && !busy && !clear && (wr_data <= CODE_MAX) && !full;
    assign last      = (({1'b0, idx} + LW'(1)) == len);
    assign nxt_idx   = last ? '0 : idx + AW'(1);
    // From IDLE the first character is fetched; otherwise the one after idx (wrapping on loop).
    assign rd_addr   = (state == ST_IDLE) ? '0 : nxt_idx;
    assign rd_safe   = (rd_code > CODE_MAX) ? '0 : rd_code;
    assign step_now  = tick && (timer == 8'd1) &&
                       ((state == ST_GAP) || ((state == ST_SHOW) && (GAP_TICKS == 0)));

    msg_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (len[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            timer <= 8'd0;
            code  <= '0;
            blank <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            len   <= '0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (clear && !busy) begin
                len <= '0;
                err <= 1'b0;
            end else if (wr_en && !busy) begin
                if ((wr_data > CODE_MAX) || full) begin
                    err <= 1'b1;
                end else begin
                    len <= len + LW'(1);
                end
            end

            if (stop) begin
                state <= ST_IDLE;
                idx   <= '0;
                timer <= 8'd0;
                code  <= '0;
                blank <= 1'b1;
                busy  <= 1'b0;
            end else if (step_now) begin
                done <= last;
                if (last && !loop_active) begin
                    state <= ST_IDLE;
                    idx   <= '0;
                    timer <= 8'd0;
                    code  <= '0;
                    blank <= 1'b1;
                    busy  <= 1'b0;
                end else begin
                    state <= ST_SHOW;
                    idx   <= nxt_idx;
                    timer <= dwell_eff;
                    code  <= rd_safe;
                    blank <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (play && (len != '0)) begin
                            state <= ST_SHOW;
                            idx   <= '0;
                            timer <= dwell_eff;
                            code  <= rd_safe;
                            blank <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (tick) begin
                            if (timer == 8'd1) begin
                                state <= ST_GAP;
                                timer <= 8'(GAP_TICKS);
                                blank <= 1'b1;
                            end else begin
                                timer <= timer - 8'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (tick) begin
                            timer <= timer - 8'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        code  <= '0;
                        blank <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msg_sequencer.sv
// tb/tb_msg_sequencer.sv - directed self-checking bench for msg_sequencer
module tb_msg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, tick, wr_en, clear, play, stop, loop;
    logic [3:0] wr_data;
    logic [7:0] dwell;
    logic [3:0] code;
    logic       blank, busy, done, err;
    logic [4:0] len;

    int n_cmp = 0;
    int n_bad = 0;
    int tick_mode = 0;
    int tick_cnt = 0;

    always #5 clk = ~clk;

    msg_sequencer #(.DEPTH(16), .GAP_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .wr_en(wr_en), .wr_data(wr_data),
        .clear(clear), .play(play), .stop(stop), .loop(loop), .dwell(dwell),
        .code(code), .blank(blank), .busy(busy), .done(done), .len(len), .err(err)
    );

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_cnt++;
            tick = (tick_mode == 1) || ((tick_mode == 4) && (tick_cnt % 4 == 0));
        end
    end

    task automatic wr(input logic [3:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({code, blank, busy, done, len, err} !== {4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got code=%0d blank=%b busy=%b done=%b len=%0d err=%b, need 0 1 0 0 0 0",
                     code, blank, busy, done, len, err);
        end
    endtask

    task automatic test_playback();
        logic [6:0] exp;
        pulse_clear();
        wr(4'd1); wr(4'd2); wr(4'd3);
        n_cmp++;
        if (len !== 5'd3) begin
            n_bad++;
            $display("FAIL pb_len: got %0d need 3", len);
        end
        dwell = 8'd2;
        tick_mode = 1;
        pulse_play();
        for (int i = 0; i < 12; i++) begin
            exp = {4'(i / 4 + 1), ((i % 4) >= 2), 1'b1, 1'b0};
            n_cmp++;
            if ({code, blank, busy, done} !== exp) begin
                n_bad++;
                $display("FAIL pb_seq[%0d]: got code=%0d blank=%b busy=%b done=%b, need code=%0d blank=%b busy=1 done=0",
                         i, code, blank, busy, done, exp[6:3], exp[2]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({code, blank, busy, done} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL pb_end: got code=%0d blank=%b busy=%b done=%b, need 0 1 0 1", code, blank, busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++;
            $display("FAIL pb_done_once: got done=%b need 0", done);
        end
        tick_mode = 0;
    endtask

    task automatic test_err_code();
        pulse_clear();
        wr(4'd11);
        n_cmp++;
        if ({err, len} !== {1'b1, 5'd0}) begin
            n_bad++;
            $display("FAIL err_illegal: got err=%b len=%0d need 1 0", err, len);
        end
        pulse_clear();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: got err=%b need 0", err);
        end
        pulse_play();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL play_empty: got busy=%b need 0", busy);
        end
        wr(4'd5);
        clear = 1'b1; wr_en = 1'b1; wr_data = 4'd3;
        @(negedge clk);
        clear = 1'b0; wr_en = 1'b0;
        n_cmp++;
        if (len !== 5'd0) begin
            n_bad++;
            $display("FAIL clear_wins: got len=%0d need 0", len);
        end
    endtask

    task automatic test_overflow();
        pulse_clear();
        for (int i = 0; i < 17; i++) wr(4'(i % 10));
        n_cmp++;
        if ({len, err} !== {5'd16, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_len: got len=%0d err=%b need 16 1", len, err);
        end
        dwell = 8'd1;
        tick_mode = 1;
        pulse_play();
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if ({code, blank, busy} !== {4'(k % 10), 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL ovf_char[%0d]: got code=%0d blank=%b busy=%b need %0d 0 1", k, code, blank, busy, k % 10);
            end
            repeat (3) @(negedge clk);
        end
        n_cmp++;
        if ({busy, done} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_end: got busy=%b done=%b need 0 1", busy, done);
        end
        tick_mode = 0;
    endtask

    task automatic test_stop();
        int done_seen = 0;
        pulse_clear();
        wr(4'd4); wr(4'd5);
        dwell = 8'd3;
        tick_mode = 1;
        pulse_play();
        for (int i = 0; i < 5; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if ({code, blank} !== {4'd5, 1'b0}) begin
            n_bad++;
            $display("FAIL stop_pre: got code=%0d blank=%b need 5 0", code, blank);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        n_cmp++;
        if ({blank, busy, done} !== {1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL stop_idle: got blank=%b busy=%b done=%b need 1 0 0", blank, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_bad++;
            $display("FAIL stop_no_done: got %0d done pulses need 0", done_seen);
        end
        tick_mode = 0;
    endtask

    task automatic test_loop();
        pulse_clear();
        wr(4'd9); wr(4'd10);
        dwell = 8'd1;
        loop = 1'b1;
        tick_mode = 1;
        pulse_play();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({code, blank} !== {4'd10, 1'b0}) begin
            n_bad++;
            $display("FAIL loop_dp: got code=%0d blank=%b need 10 0", code, blank);
        end
        repeat (3) @(negedge clk);
`ifdef MSG_SEQUENCER_LOOP_EN
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if ({code, blank, busy, done} !== {4'd9, 1'b0, 1'b1, 1'b1}) begin
                n_bad++;
                $display("FAIL loop_pass[%0d]: got code=%0d blank=%b busy=%b done=%b need 9 0 1 1",
                         p, code, blank, busy, done);
            end
            repeat (6) @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
`else
        n_cmp++;
        if ({code, blank, busy, done} !== {4'd0, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL loop_single: got code=%0d blank=%b busy=%b done=%b need 0 1 0 1", code, blank, busy, done);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL loop_stays_idle: got busy=%b need 0", busy);
        end
`endif
        loop = 1'b0;
        tick_mode = 0;
    endtask

    task automatic test_dwell0_reset();
        int shown8 = 0;
        int guard  = 0;
        pulse_clear();
        wr(4'd7); wr(4'd8);
        dwell = 8'd0;
        tick_mode = 4;
        pulse_play();
        while (busy === 1'b1 && guard < 100) begin
            if (code === 4'd8 && blank === 1'b0) shown8++;
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 100) begin
            n_bad++;
            $display("FAIL d0_timeout: playback still busy after %0d cycles", guard);
        end
        n_cmp++;
        if (shown8 !== 4) begin
            n_bad++;
            $display("FAIL d0_dwell: got %0d cycles of char 8 need 4", shown8);
        end
        pulse_play();
        guard = 0;
        while (blank !== 1'b0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (blank !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_show: got blank=%b need 0 before reset", blank);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({code, blank, busy, done, len, err} !== {4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_async: got code=%0d blank=%b busy=%b done=%b len=%0d err=%b, need 0 1 0 0 0 0",
                     code, blank, busy, done, len, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick_mode = 0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_data = 4'd0; clear = 1'b0; play = 1'b0;
        stop = 1'b0; loop = 1'b0; dwell = 8'd1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_playback();
        test_err_code();
        test_overflow();
        test_stop();
        test_loop();
        test_dwell0_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/msg_sequencer.md
MSG_SEQUENCER -- requirements
Module: msg_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, message buffer entries (power of 2).
REQ-002 SHALL have parameter GAP_TICKS, default 2, blank ticks between characters (0 = no gap).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tick  input  1  single-cycle timebase enable.
REQ-006 SHALL have port wr_en  input  1  append wr_data to buffer.
REQ-007 SHALL have port wr_data  input  4  character code: 0-9 digit, 10 decimal point.
REQ-008 SHALL have port clear  input  1  empty buffer, clear err.
REQ-009 SHALL have port play  input  1  start playback pulse.
REQ-010 SHALL have port stop  input  1  abort playback.
REQ-011 SHALL have port loop  input  1  repeat message (effective only with LOOP_EN).
REQ-012 SHALL have port dwell  input  8  ticks each character is shown (0 treated as 1).
REQ-013 SHALL have port code  output  4  current character to the segment decoder.
REQ-014 SHALL have port blank  output  1  display dark; downstream gates segments off.
REQ-015 SHALL have port busy  output  1  playback in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of message.
REQ-017 SHALL have port len  output  $clog2(DEPTH)+1  stored character count.
REQ-018 SHALL have port err  output  1  sticky: illegal code or overflow write dropped.

Function
REQ-019 All outputs SHALL be registered; code is never 11-15.
REQ-020 wr_en with !busy, wr_data<=10, len<DEPTH: store at index len, len+1 next cycle.
REQ-021 wr_en with wr_data>10 or len==DEPTH: write dropped, err=1; wr_en while busy: ignored, err unchanged.
REQ-022 clear (only when !busy): len=0, err=0; clear and wr_en same cycle -> clear wins, write dropped.
REQ-023 FSM states IDLE, SHOW, GAP; IDLE: blank=1, code=0, busy=0.
REQ-024 IDLE + play + len>0 -> SHOW, idx=0, timer=max(dwell,1); code/blank valid cycle after play; play with len==0 ignored.
REQ-025 SHOW: code=buf[idx], blank=0; timer decrements on tick; tick with timer==1 -> GAP (timer=GAP_TICKS), or directly to next step if GAP_TICKS==0.
REQ-026 GAP: blank=1, code holds; tick with timer==1 -> next step.
REQ-027 Next step: idx<len-1 -> idx+1, SHOW; idx==len-1 -> end-of-message.
REQ-028 End-of-message: done=1 one cycle; loop active -> idx=0, SHOW; else IDLE.
REQ-029 dwell sampled at each SHOW entry; changes mid-character take effect on next character.
REQ-030 stop in any state -> IDLE next cycle, blank=1, no done pulse; stop beats play same cycle.
REQ-031 play while busy ignored; tick while IDLE has no effect.

Reset
REQ-032 rst_n low: state IDLE, code=0, blank=1, busy=0, done=0, len=0, err=0, idx=0, timer=0; buffer contents need not reset.
REQ-033 Reset mid-playback SHALL abort immediately with no done pulse.

Configuration
REQ-034 Macro MSG_SEQUENCER_LOOP_EN defined: loop input honoured per REQ-028.
REQ-035 Macro undefined: loop ignored, every message ends in IDLE; loop port still present.

Structure
REQ-036 Shared package msg_pkg SHALL hold CODE_W=4, CODE_DP=10, CODE_MAX=10 and the state enum.
REQ-037 Buffer SHALL be sub-module msg_buffer (DEPTH x 4 register file, one write port, one async read port).

Verification
REQ-038 Write 1,2,3; dwell=2, GAP_TICKS=2, tick every cycle; play -> code 1,1,(gap 2),2,2,(gap 2),3,3,(gap 2); done once; busy low after.
REQ-039 Write 11 -> err=1, len=0; clear -> err=0.
REQ-040 Write 17 legal codes at DEPTH=16 -> len=16, err=1; playback shows 16 characters only.
REQ-041 Play 2-char message, stop during second SHOW -> blank=1 next cycle, busy=0, done never pulses.
REQ-042 MSG_SEQUENCER_LOOP_EN defined, loop=1, message 9,10 -> sequence repeats, done pulses each pass; undefined -> single pass.
REQ-043 dwell=0, tick every 4th cycle -> each character shown exactly 1 tick (4 cycles); rst_n low mid-SHOW -> all outputs at reset values asynchronously.
